// File: rtl/lutram_chk_pkg.sv
// Shared definitions for the LUTRAM read checker.
//   chk_state_e   : checker FSM encoding (IDLE / CHECK / DONE, 2 bits)
//   NUM_WORDS     : words per pass for the default address width
//   expected_word : the write pattern the test FSM stores at an address
package lutram_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_e;

    localparam int DEFAULT_A_WIDTH = 5;
    localparam int NUM_WORDS       = 2 ** DEFAULT_A_WIDTH;
    localparam int MAX_D_WIDTH     = 32;

    // Address zero-extended/truncated to d_width bits, then XOR'd with the
    // pattern mask. For d_width=1 this is addr[0].
    function automatic logic [MAX_D_WIDTH-1:0] expected_word(
        input logic [MAX_D_WIDTH-1:0] addr,
        input int unsigned            d_width,
        input logic [MAX_D_WIDTH-1:0] xor_mask
    );
        logic [MAX_D_WIDTH-1:0] keep;
        keep = (d_width >= MAX_D_WIDTH) ? '1 : ((32'd1 << d_width) - 32'd1);
        return (addr ^ xor_mask) & keep;
    endfunction

endpackage

// File: rtl/lutram_chk_delay.sv
// Aligns the read beat qualifier/address with the RAM data.
//   clk_i, rst_i : clock, async active-high reset
//   flush_i      : synchronous clear of the stage (drops stale beats)
//   valid_i/addr_i -> valid_o/addr_o delayed by DEPTH cycles (0 or 1)
module lutram_chk_delay #(
    parameter int A_WIDTH = 5,
    parameter int DEPTH   = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [A_WIDTH-1:0] addr_i,
    output logic               valid_o,
    output logic [A_WIDTH-1:0] addr_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Async-read RAM: the beat and its data coincide.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk_i, rst_i, flush_i};
            assign valid_o = valid_i;
            assign addr_o  = addr_i;
        end else begin : g_reg
            logic               valid_q;
            logic [A_WIDTH-1:0] addr_q;
            // NOTE: state registers use non-blocking (<=) so every flop samples
            // pre-edge values regardless of process ordering.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    addr_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                    addr_q  <= '0;
                end else begin
                    valid_q <= valid_i;
                    addr_q  <= addr_i;
                end
            end
            assign valid_o = valid_q;
            assign addr_o  = addr_q;
        end
    endgenerate

endmodule

// File: rtl/lutram_read_checker.sv
// Checks the READ-phase address/data stream of a LUTRAM test against the
// written pattern and reports pass/fail on LED/ILA-friendly status outputs.
//   clk_i, rst_i          : clock, async active-high reset
//   start_i               : arms a pass (ignored while checking)
//   rd_valid_i/rd_addr_i  : read beat; rd_data_i arrives READ_LATENCY later
//   busy_o / done_o       : pass in progress / pass complete (sticky)
//   pass_o                : no errors in the pass, valid when done_o=1
//   err_count_o           : saturating data+sequence error count
//   seq_err_o             : an out-of-order address was seen
//   first_err_valid_o/first_err_addr_o : address of the first failing beat
module lutram_read_checker
    import lutram_chk_pkg::*;
#(
    parameter int                 A_WIDTH      = DEFAULT_A_WIDTH,
    parameter int                 D_WIDTH      = 1,
    parameter int                 READ_LATENCY = 0,
    parameter logic [D_WIDTH-1:0] PATTERN_XOR  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               rd_valid_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    input  logic [D_WIDTH-1:0] rd_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH:0]   err_count_o,
    output logic               seq_err_o,
    output logic               first_err_valid_o,
    output logic [A_WIDTH-1:0] first_err_addr_o
);

    // The package constant describes the default build; other widths derive it.
    localparam int WORDS = (A_WIDTH == DEFAULT_A_WIDTH) ? NUM_WORDS : (1 << A_WIDTH);

    chk_state_e state_q, state_d;

    logic               flush;
    logic               cmp_valid;
    logic [A_WIDTH-1:0] cmp_addr;
    logic [D_WIDTH-1:0] exp_data;
    logic [A_WIDTH-1:0] exp_idx_q;
    logic [A_WIDTH:0]   beat_cnt_q;
    logic               data_err, addr_err, beat_err, last_beat, in_check;
    logic [A_WIDTH:0]   err_next;

    // Arming from IDLE or DONE clears everything, including in-flight beats.
    assign flush = start_i && (state_q != CHECK);

    lutram_chk_delay #(
        .A_WIDTH (A_WIDTH),
        .DEPTH   (READ_LATENCY)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .valid_i (rd_valid_i),
        .addr_i  (rd_addr_i),
        .valid_o (cmp_valid),
        .addr_o  (cmp_addr)
    );

    assign exp_data  = D_WIDTH'(expected_word(32'(cmp_addr), D_WIDTH, 32'(PATTERN_XOR)));
    assign in_check  = (state_q == CHECK) && cmp_valid;
    assign data_err  = rd_data_i != exp_data;
    assign addr_err  = cmp_addr != exp_idx_q;
    assign beat_err  = in_check && (data_err || addr_err);
    assign last_beat = in_check && (beat_cnt_q == (A_WIDTH+1)'(WORDS - 1));
    // A beat with both error kinds counts once; the count sticks at WORDS.
    assign err_next  = (beat_err && (err_count_o != (A_WIDTH+1)'(WORDS)))
                       ? err_count_o + 1'b1 : err_count_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = CHECK;
            CHECK:   if (last_beat) state_d = DONE;
            DONE:    if (start_i)   state_d = CHECK;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_o            <= 1'b0;
            err_count_o       <= '0;
            seq_err_o         <= 1'b0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
            exp_idx_q         <= '0;
            beat_cnt_q        <= '0;
        end else if (flush) begin
            pass_o            <= 1'b0;
            err_count_o       <= '0;
            seq_err_o         <= 1'b0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
            exp_idx_q         <= '0;
            beat_cnt_q        <= '0;
        end else if (in_check) begin
            err_count_o <= err_next;
            if (addr_err) seq_err_o <= 1'b1;
            if (beat_err && !first_err_valid_o) begin
                first_err_valid_o <= 1'b1;
                first_err_addr_o  <= cmp_addr;
            end
            exp_idx_q  <= exp_idx_q + 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // Verdict includes the final beat's own result.
            if (last_beat) pass_o <= (err_next == '0);
        end
    end

    assign busy_o = (state_q == CHECK);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_lutram_read_checker.sv
module tb_lutram_read_checker;

    localparam int AW = 5;
    localparam int NW = 32;

    typedef enum int {K_CLEAN, K_DATA7, K_SEQDUP, K_INVERT, K_L1_ALIGNED, K_L1_SHIFTED} kind_e;

    typedef struct {
        kind_e kind;
        int    lat;
        int    exp_pass;
        int    exp_err;
        int    exp_seq;
        int    exp_fv;
        int    exp_fa;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          rd_valid_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [0:0]    rd_data_i = '0;

    logic          busy_0, done_0, pass_0, seq_0, fv_0;
    logic [AW:0]   err_0;
    logic [AW-1:0] fa_0;
    logic          busy_1, done_1, pass_1, seq_1, fv_1;
    logic [AW:0]   err_1;
    logic [AW-1:0] fa_1;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t exp_q[$];

    always #5 clk_i = ~clk_i;

    lutram_read_checker #(.A_WIDTH(AW), .D_WIDTH(1), .READ_LATENCY(0), .PATTERN_XOR(1'b0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rd_valid_i(rd_valid_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .busy_o(busy_0), .done_o(done_0),
        .pass_o(pass_0), .err_count_o(err_0), .seq_err_o(seq_0),
        .first_err_valid_o(fv_0), .first_err_addr_o(fa_0));

    lutram_read_checker #(.A_WIDTH(AW), .D_WIDTH(1), .READ_LATENCY(1), .PATTERN_XOR(1'b0)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rd_valid_i(rd_valid_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .busy_o(busy_1), .done_o(done_1),
        .pass_o(pass_1), .err_count_o(err_1), .seq_err_o(seq_1),
        .first_err_valid_o(fv_1), .first_err_addr_o(fa_1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic get_status(input int lat, output logic [31:0] busy, output logic [31:0] done,
                              output logic [31:0] pass, output logic [31:0] err,
                              output logic [31:0] seq, output logic [31:0] fv,
                              output logic [31:0] fa);
        if (lat == 0) begin
            busy = 32'(busy_0); done = 32'(done_0); pass = 32'(pass_0); err = 32'(err_0);
            seq = 32'(seq_0); fv = 32'(fv_0); fa = 32'(fa_0);
        end else begin
            busy = 32'(busy_1); done = 32'(done_1); pass = 32'(pass_1); err = 32'(err_1);
            seq = 32'(seq_1); fv = 32'(fv_1); fa = 32'(fa_1);
        end
    endtask

    task automatic check_all_zero(input string tag, input int lat);
        logic [31:0] b, d, p, e, s, v, a;
        get_status(lat, b, d, p, e, s, v, a);
        check({tag, "_busy"}, b, 0);
        check({tag, "_done"}, d, 0);
        check({tag, "_pass"}, p, 0);
        check({tag, "_err"}, e, 0);
        check({tag, "_seq"}, s, 0);
        check({tag, "_fv"}, v, 0);
        check({tag, "_fa"}, a, 0);
    endtask

    task automatic idle(input int n);
        rd_valid_i = 1'b0; rd_addr_i = '0; rd_data_i = '0; start_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drives 32 beats for the given scenario. Latency-0 kinds are contiguous;
    // latency-1 kinds use random gaps of 1..3 cycles between beats.
    task automatic run_stream(input kind_e kind);
        logic [AW-1:0] a;
        logic          d;
        logic          pend;
        int            gap;
        bit            gapped;
        pend   = 1'b0;
        gapped = (kind == K_L1_ALIGNED) || (kind == K_L1_SHIFTED);
        for (int pos = 0; pos < NW; pos++) begin
            a = AW'(pos);
            if (kind == K_SEQDUP && pos == 4) a = AW'(3);
            d = a[0];
            if (kind == K_DATA7 && a == AW'(7)) d = 1'b0;
            if (kind == K_INVERT) d = ~d;
            if (gapped) begin
                gap = $urandom_range(3, 1);
                repeat (gap) begin
                    rd_valid_i = 1'b0; rd_addr_i = '0;
                    rd_data_i  = (kind == K_L1_ALIGNED) ? pend : 1'b0;
                    pend = 1'b0;
                    @(negedge clk_i);
                end
            end
            rd_valid_i = 1'b1;
            rd_addr_i  = a;
            rd_data_i  = (kind == K_L1_ALIGNED) ? pend : d;
            pend = d;
            @(negedge clk_i);
        end
        rd_valid_i = 1'b0; rd_addr_i = '0;
        rd_data_i  = (kind == K_L1_ALIGNED) ? pend : 1'b0;
        @(negedge clk_i);
        rd_data_i  = '0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        logic [31:0] b, d, p, e, s, v, a;
        int cyc;
        cyc = 0;
        get_status(lat, b, d, p, e, s, v, a);
        while (d != 1 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
            get_status(lat, b, d, p, e, s, v, a);
        end
        check({tag, "_done_seen"}, d, 1);
    endtask

    task automatic pop_and_compare(input string tag);
        vec_t x;
        logic [31:0] b, d, p, e, s, v, a;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            return;
        end
        x = exp_q.pop_front();
        get_status(x.lat, b, d, p, e, s, v, a);
        check({tag, "_busy"}, b, 0);
        check({tag, "_pass"}, p, 32'(x.exp_pass));
        check({tag, "_err"}, e, 32'(x.exp_err));
        check({tag, "_seq"}, s, 32'(x.exp_seq));
        check({tag, "_fv"}, v, 32'(x.exp_fv));
        if (x.exp_fv != 0) check({tag, "_fa"}, a, 32'(x.exp_fa));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{K_CLEAN,      0, 1,  0, 0, 0, 0};
        vecs[1] = '{K_DATA7,      0, 0,  1, 0, 1, 7};
        vecs[2] = '{K_SEQDUP,     0, 0,  1, 1, 1, 3};
        vecs[3] = '{K_INVERT,     0, 0, 32, 0, 1, 0};
        vecs[4] = '{K_L1_ALIGNED, 1, 1,  0, 0, 0, 0};
        vecs[5] = '{K_L1_SHIFTED, 1, 0, 16, 0, 1, 1};
        vecs[6] = '{K_CLEAN,      0, 1,  0, 0, 0, 0};

        // Reset state, then no start: outputs must stay 0.
        #2;
        check_all_zero("reset0", 0);
        check_all_zero("reset1", 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        idle(4);
        check_all_zero("nostart0", 0);
        check_all_zero("nostart1", 1);

        // Table-driven passes through the scoreboard.
        foreach (vecs[i]) begin
            pulse_start();
            exp_q.push_back(vecs[i]);
            run_stream(vecs[i].kind);
            wait_done($sformatf("vec%0d", i), vecs[i].lat);
            pop_and_compare($sformatf("vec%0d", i));
            idle(4);
        end

        // Restart from DONE after a failing pass clears status at once.
        pulse_start();
        run_stream(K_INVERT);
        wait_done("inv", 0);
        check("inv_err", 32'(err_0), 32);
        idle(4);
        pulse_start();
        check("restart_err_clear", 32'(err_0), 0);
        check("restart_fv_clear", 32'(fv_0), 0);
        check("restart_done_clear", 32'(done_0), 0);
        check("restart_busy", 32'(busy_0), 1);
        run_stream(K_CLEAN);
        wait_done("restart", 0);
        check("restart_pass", 32'(pass_0), 1);
        idle(4);

        // Async reset mid-pass after beat 10 abandons it completely.
        pulse_start();
        for (int pos = 0; pos <= 10; pos++) begin
            rd_valid_i = 1'b1;
            rd_addr_i  = AW'(pos);
            rd_data_i  = ~rd_addr_i[0];
            @(negedge clk_i);
        end
        rd_valid_i = 1'b0;
        check("mid_busy", 32'(busy_0), 1);
        check("mid_err", 32'(err_0), 11);
        #2 rst_i = 1'b1;
        #1;
        check_all_zero("midrst0", 0);
        check_all_zero("midrst1", 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(3);

        // Clean pass with exact done timing: done one cycle after beat 31.
        pulse_start();
        for (int pos = 0; pos < NW; pos++) begin
            rd_valid_i = 1'b1;
            rd_addr_i  = AW'(pos);
            rd_data_i  = rd_addr_i[0];
            if (pos == NW - 1) begin
                check("last_beat_busy", 32'(busy_0), 1);
                check("last_beat_not_done", 32'(done_0), 0);
            end
            @(negedge clk_i);
        end
        rd_valid_i = 1'b0; rd_data_i = '0;
        check("final_done", 32'(done_0), 1);
        check("final_busy", 32'(busy_0), 0);
        check("final_pass", 32'(pass_0), 1);
        check("final_err", 32'(err_0), 0);
        check("final_seq", 32'(seq_0), 0);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lutram_read_checker.md
Name: lutram_read_checker

Overview:
- Downstream consumer of the LUTRAM primitive tests: takes the address/data stream the test FSM produces during its READ phase and checks every read word against the written pattern.
- Counts data and sequencing errors, latches the first failing address, and reports pass/fail on status outputs sized for LEDs/ILA.
- Handles both async-read LUTRAM (RAM32X1S-style, latency 0) and registered-output configurations (latency 1).

Parameters:
- A_WIDTH, 5, address width; one pass covers 2**A_WIDTH words.
- D_WIDTH, 1, read data width.
- READ_LATENCY, 0, cycles from rd_valid_i/rd_addr_i to matching rd_data_i; legal values 0 or 1.
- PATTERN_XOR, 0 (D_WIDTH bits), XOR mask applied to the expected word.

Ports:
- clk_i  in  1  single clock; test clk_div domain.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that arms a check pass.
- rd_valid_i  in  1  read beat qualifier.
- rd_addr_i  in  A_WIDTH  address of the beat.
- rd_data_i  in  D_WIDTH  RAM output, READ_LATENCY cycles after rd_valid_i.
- busy_o  out  1  pass in progress.
- done_o  out  1  sticky; pass complete.
- pass_o  out  1  sticky; valid only when done_o=1.
- err_count_o  out  A_WIDTH+1  data+sequence error count, saturating.
- seq_err_o  out  1  sticky; address-order violation seen.
- first_err_valid_o  out  1  first_err_addr_o holds a captured address.
- first_err_addr_o  out  A_WIDTH  address of first failing beat.

Behaviour:
- Reset (async, any time): all outputs 0; FSM=IDLE; delay line, beat counter, expected index cleared. Reset mid-pass abandons the pass with no partial status.
- Expected word for address a: zero-extend/truncate a to D_WIDTH, XOR PATTERN_XOR. D_WIDTH=1 gives a[0], which matches the test FSM write pattern.
- Alignment: rd_valid_i and rd_addr_i pass through a READ_LATENCY-deep delay line. Latency 0 means a wire. The compare happens on the delayed valid (cmp_valid) against the current rd_data_i.
- FSM states:
  - IDLE: start_i -> CHECK. Clears err_count_o, seq_err_o, first_err_*, done_o, pass_o, beat counter and expected index. The delay line is flushed so stale beats are not compared.
  - CHECK: busy_o=1. On each cmp_valid:
    - data_err = rd_data_i != expected(delayed addr).
    - addr_err = delayed addr != expected index.
    - If either error: err_count_o += 1, saturating at 2**A_WIDTH. If first_err_valid_o=0, capture the delayed addr and set first_err_valid_o.
    - addr_err also sets seq_err_o.
    - Expected index and beat counter increment; the index wraps at 2**A_WIDTH.
    - On the 2**A_WIDTH-th compared beat -> DONE.
  - DONE: registered; entered the cycle after the last compared beat. done_o=1, busy_o=0. pass_o = (err_count_o==0 including the last beat's result). Holds until start_i, which restarts as from IDLE with the same-cycle clear.
- start_i in CHECK is ignored. rd_valid_i in IDLE/DONE is ignored. Gaps in rd_valid_i are legal and stall nothing.
- A beat that has both a data and an address error counts once.
- Illegal FSM encoding -> IDLE.

Decomposition:
- Package lutram_chk_pkg holds:
  - state encodings IDLE/CHECK/DONE (2-bit);
  - a function expected_word(addr) parameterised by D_WIDTH/PATTERN_XOR;
  - the localparam NUM_WORDS = 2**A_WIDTH.
- One sub-module, lutram_chk_delay: parameterised-depth (0..1) register line for {valid, addr}, cleared by rst_i and by the flush.

Test Plan:
Defaults unless noted (A_WIDTH=5, D_WIDTH=1, latency 0).
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately; after release, with no start_i, outputs stay 0.
- Clean pass: start_i, then 32 contiguous beats addr 0..31 with data=addr[0] -> busy_o=1 during beats; done_o=1 and pass_o=1 one cycle after beat 31; err_count_o=0; seq_err_o=0.
- Single data error: same stream but addr 7 data=0 -> done_o=1, pass_o=0, err_count_o=1, first_err_addr_o=7, first_err_valid_o=1.
- READ_LATENCY=1 with gaps: beats at random spacing, data one cycle after valid -> pass_o=1. Then shift data to latency 0 (misaligned) -> pass_o=0, err_count_o=16.
- Sequence error: addr order 0,1,2,3,3,5..31 (32 beats) -> seq_err_o=1, first_err_addr_o=3 (second occurrence), err_count_o≥1, pass_o=0.
- Saturation and restart:
  - All 32 beats inverted -> err_count_o=32, no wrap.
  - start_i in DONE -> counters clear; a clean pass gives pass_o=1.
  - rst_i after beat 10 of a pass -> outputs 0; a new clean pass gives pass_o=1.
